dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Arbitrates the single-port data memory between the pipeline memory stage ("core") and an auxiliary requester ("aux", e.g. debug loader / DMA).
- Grants at most one access per cycle, with fixed core priority plus starvation protection for aux.
- Routes the 1-cycle-latency read data back to whichever requester owned the access.
- Drives the core stall when the core loses arbitration.

Parameters:
- STARVE_LIMIT, 4, consecutive aux-waiting cycles before aux is forced to win; legal range 1..255.
- ADDR_W, 11, word-address bits forwarded to the memory (2048 words).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  synchronous active-low reset
- core_req_i  in  1  core access request
- core_we_i  in  1  1 = store, 0 = load
- core_funct3_i  in  3  access size (000 byte, 001 half, 010 word)
- core_addr_i  in  32  core address
- core_wdata_i  in  32  core store data
- core_gnt_o  out  1  core access accepted this cycle
- core_stall_o  out  1  core_req_i & !core_gnt_o
- core_rvalid_o  out  1  core read data valid
- core_rdata_o  out  32  core read data
- aux_req_i  in  1  aux request
- aux_we_i  in  1  aux store/load
- aux_funct3_i  in  3  aux size
- aux_addr_i  in  32  aux address
- aux_wdata_i  in  32  aux store data
- aux_gnt_o  out  1  aux accepted
- aux_rvalid_o  out  1  aux read data valid
- aux_rdata_o  out  32  aux read data
- mem_en_o  out  1  memory access strobe
- mem_we_o  out  1  memory write enable
- mem_funct3_o  out  3  forwarded size
- mem_addr_o  out  ADDR_W  memory word address = winner addr[ADDR_W-1:0]
- mem_wdata_o  out  32  forwarded store data
- mem_rdata_i  in  32  memory read data, valid the cycle after a read is issued
- perf_stall_cnt_o  out  32  core stall cycles (optional feature)
- perf_aux_cnt_o  out  32  aux grants (optional feature)

Behaviour:
- Reset (rstn_i=0 at a clock edge): state=PRIO_CORE, starve_cnt=0, owner/read-pending flags cleared, all rvalid=0, perf counters=0. Any read in flight is dropped and no rvalid is issued for it.
- Grants are combinational from current requests and state. Only the winner's fields drive mem_*. mem_en_o=0 when there is no grant; the other mem_* outputs are 0 in that case.
- State PRIO_CORE:
  - core_req → core wins.
  - aux_req with no core_req → aux wins.
  - If aux_req & core_req, starve_cnt increments. When it reaches STARVE_LIMIT, the next state is PRIO_AUX.
  - Any aux grant clears starve_cnt.
  - A cycle with no aux_req clears starve_cnt.
- State PRIO_AUX:
  - aux_req → aux wins, core stalls. Return to PRIO_CORE, starve_cnt=0.
  - If aux_req dropped → core wins if requesting. Return to PRIO_CORE, starve_cnt=0.
  - PRIO_AUX lasts exactly one cycle.
- Read response:
  - A read grant registers rd_pend=1 and owner (core/aux).
  - Next cycle, the owner's rvalid=1 and its rdata=mem_rdata_i. The non-owner's rdata=0.
  - rvalid pulses are one cycle wide and never assert for stores.
  - Back-to-back reads from alternating owners give back-to-back rvalids, each routed correctly.
- Simultaneous events:
  - A read response and a new grant in the same cycle are independent.
  - Requesters may hold req across cycles; each granted cycle is one access.
- Illegal funct3 (not 000/001/010) with we=1: granted, but mem_en_o forced 0 (no write). Loads pass funct3 through.
- Width: addr upper bits [31:ADDR_W] are ignored. No alignment checking.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- Defined:
  - perf_stall_cnt_o increments each cycle core_stall_o=1.
  - perf_aux_cnt_o increments on each aux grant.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Core only: read addr 0x10 with mem_rdata_i=0xDEADBEEF → core_gnt_o=1 same cycle, mem_addr_o=0x010; next cycle core_rvalid_o=1, core_rdata_o=0xDEADBEEF, aux_rvalid_o=0.
- Contention, STARVE_LIMIT=4, core and aux requesting continuously → core wins cycles 0-3, aux wins cycle 4 with core_stall_o=1, core wins cycle 5; pattern repeats every 5 cycles.
- Aux idle then alone: aux store word 0xCAFEF00D to 0x7FC, core idle → aux_gnt_o=1, mem_we_o=1, mem_addr_o=0x7FC, mem_wdata_o=0xCAFEF00D; no rvalid.
- Alternating reads (core 0x4, then aux 0x8, back-to-back) → core_rvalid_o on cycle 1 and aux_rvalid_o on cycle 2, each carrying that cycle's mem_rdata_i.
- Reset mid-read: grant core read, assert rstn_i=0 next edge → no core_rvalid_o; starve_cnt and state back to PRIO_CORE; perf counters=0.
- Store funct3=011 from core → core_gnt_o=1, mem_en_o=0. With DMEM_ARB_PERF_EN, 3 stall cycles → perf_stall_cnt_o=3.

Source files
------------

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter
// ----------------------------------------------------------------------------
// Shares the single-port data memory between the pipeline memory stage
// ("core") and an auxiliary requester ("aux", e.g. debug loader or DMA).
// At most one access is granted per cycle. The core has fixed priority, but
// after STARVE_LIMIT consecutive cycles in which aux waited behind the core,
// aux is forced to win for exactly one cycle. Read data returns one cycle
// after the read is issued and is steered to whichever requester owned it.
//
// Parameters:
//   STARVE_LIMIT  consecutive aux-waiting cycles before aux is forced to win
//                 (legal range 1..255)
//   ADDR_W        word-address bits forwarded to the memory
//
// Ports:
//   clk_i, rstn_i                clock, synchronous active-low reset
//   core_req_i/we/funct3/addr/wdata   core request fields
//   core_gnt_o, core_stall_o     core accepted / core waiting this cycle
//   core_rvalid_o, core_rdata_o  core read response (1 cycle after grant)
//   aux_req_i/we/funct3/addr/wdata    aux request fields
//   aux_gnt_o                    aux accepted this cycle
//   aux_rvalid_o, aux_rdata_o    aux read response
//   mem_en_o, mem_we_o, mem_funct3_o, mem_addr_o, mem_wdata_o
//                                winner's access forwarded to the memory
//   mem_rdata_i                  memory read data, valid the cycle after a read
//   perf_stall_cnt_o             core stall cycles (saturating)
//   perf_aux_cnt_o               aux grants (saturating)
//
// Build option:
//   DMEM_ARB_PERF_EN  when defined, the two saturating performance counters
//                     are built; otherwise both perf ports are tied to 0.
// ============================================================================
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 11
) (
    input  logic              clk_i,
    input  logic              rstn_i,

    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_funct3_i,
    input  logic [31:0]       core_addr_i,
    input  logic [31:0]       core_wdata_i,
    output logic              core_gnt_o,
    output logic              core_stall_o,
    output logic              core_rvalid_o,
    output logic [31:0]       core_rdata_o,

    input  logic              aux_req_i,
    input  logic              aux_we_i,
    input  logic [2:0]        aux_funct3_i,
    input  logic [31:0]       aux_addr_i,
    input  logic [31:0]       aux_wdata_i,
    output logic              aux_gnt_o,
    output logic              aux_rvalid_o,
    output logic [31:0]       aux_rdata_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [2:0]        mem_funct3_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,

    output logic [31:0]       perf_stall_cnt_o,
    output logic [31:0]       perf_aux_cnt_o
);

    typedef enum logic [0:0] {
        PRIO_CORE = 1'b0,
        PRIO_AUX  = 1'b1
    } state_e;

    localparam logic [7:0] STARVE_LIMIT_C = 8'(STARVE_LIMIT);

    // Only byte/half/word sizes may be written; anything else is suppressed.
    function automatic logic size_legal(input logic [2:0] funct3);
        logic ok;
        case (funct3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_e            state_r;
    state_e            state_next_s;
    logic [7:0]        starve_cnt_r;
    logic [7:0]        starve_cnt_next_s;

    logic              core_gnt_s;
    logic              aux_gnt_s;

    logic              sel_we_s;
    logic [2:0]        sel_funct3_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [31:0]       sel_wdata_s;

    logic              rd_pend_r;
    logic              owner_aux_r;

    // Upper address bits are deliberately ignored (word index only).
    logic              unused_addr_hi_s;
    assign unused_addr_hi_s = ^{core_addr_i[31:ADDR_W], aux_addr_i[31:ADDR_W]};

    // Arbitration state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_r      <= PRIO_CORE;
            starve_cnt_r <= 8'd0;
        end else begin
            state_r      <= state_next_s;
            starve_cnt_r <= starve_cnt_next_s;
        end
    end

    // Next-state logic: count contention cycles, force one aux cycle at the limit.
    always_comb begin
        state_next_s      = PRIO_CORE;
        starve_cnt_next_s = 8'd0;
        case (state_r)
            PRIO_CORE: begin
                // In PRIO_CORE aux only waits when the core is also requesting;
                // any other cycle either grants aux or has no aux request.
                if (aux_req_i && core_req_i) begin
                    starve_cnt_next_s = starve_cnt_r + 8'd1;
                    if ((starve_cnt_r + 8'd1) >= STARVE_LIMIT_C) begin
                        state_next_s = PRIO_AUX;
                    end else begin
                        state_next_s = PRIO_CORE;
                    end
                end else begin
                    starve_cnt_next_s = 8'd0;
                    state_next_s      = PRIO_CORE;
                end
            end
            PRIO_AUX: begin
                // Forced-aux window is a single cycle regardless of outcome.
                state_next_s      = PRIO_CORE;
                starve_cnt_next_s = 8'd0;
            end
            default: begin
                state_next_s      = PRIO_CORE;
                starve_cnt_next_s = 8'd0;
            end
        endcase
    end

    // Grant decode from current requests and priority state.
    always_comb begin
        core_gnt_s = 1'b0;
        aux_gnt_s  = 1'b0;
        case (state_r)
            PRIO_CORE: begin
                if (core_req_i) begin
                    core_gnt_s = 1'b1;
                end else if (aux_req_i) begin
                    aux_gnt_s = 1'b1;
                end else begin
                    core_gnt_s = 1'b0;
                    aux_gnt_s  = 1'b0;
                end
            end
            PRIO_AUX: begin
                if (aux_req_i) begin
                    aux_gnt_s = 1'b1;
                end else if (core_req_i) begin
                    core_gnt_s = 1'b1;
                end else begin
                    core_gnt_s = 1'b0;
                    aux_gnt_s  = 1'b0;
                end
            end
            default: begin
                core_gnt_s = 1'b0;
                aux_gnt_s  = 1'b0;
            end
        endcase
    end

    // Winner's request fields onto the memory bus; all zero when idle.
    always_comb begin
        sel_we_s     = 1'b0;
        sel_funct3_s = 3'b000;
        sel_addr_s   = {ADDR_W{1'b0}};
        sel_wdata_s  = 32'h0000_0000;
        if (core_gnt_s) begin
            sel_we_s     = core_we_i;
            sel_funct3_s = core_funct3_i;
            sel_addr_s   = core_addr_i[ADDR_W-1:0];
            sel_wdata_s  = core_wdata_i;
        end else if (aux_gnt_s) begin
            sel_we_s     = aux_we_i;
            sel_funct3_s = aux_funct3_i;
            sel_addr_s   = aux_addr_i[ADDR_W-1:0];
            sel_wdata_s  = aux_wdata_i;
        end else begin
            sel_we_s     = 1'b0;
            sel_funct3_s = 3'b000;
            sel_addr_s   = {ADDR_W{1'b0}};
            sel_wdata_s  = 32'h0000_0000;
        end
    end

    assign core_gnt_o   = core_gnt_s;
    assign aux_gnt_o    = aux_gnt_s;
    assign core_stall_o = core_req_i & ~core_gnt_s;

    // A store with an unsupported size is accepted but never reaches the array.
    assign mem_en_o     = (core_gnt_s | aux_gnt_s) & ~(sel_we_s & ~size_legal(sel_funct3_s));
    assign mem_we_o     = sel_we_s;
    assign mem_funct3_o = sel_funct3_s;
    assign mem_addr_o   = sel_addr_s;
    assign mem_wdata_o  = sel_wdata_s;

    // Remember which requester owns the read issued this cycle.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rd_pend_r   <= 1'b0;
            owner_aux_r <= 1'b0;
        end else begin
            rd_pend_r   <= (core_gnt_s | aux_gnt_s) & ~sel_we_s;
            owner_aux_r <= aux_gnt_s;
        end
    end

    assign core_rvalid_o = rd_pend_r & ~owner_aux_r;
    assign aux_rvalid_o  = rd_pend_r &  owner_aux_r;
    assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : 32'h0000_0000;
    assign aux_rdata_o   = aux_rvalid_o  ? mem_rdata_i : 32'h0000_0000;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_stall_cnt_r;
    logic [31:0] perf_aux_cnt_r;

    // Saturating event counters for stall cycles and aux grants.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            perf_stall_cnt_r <= 32'h0000_0000;
            perf_aux_cnt_r   <= 32'h0000_0000;
        end else begin
            if (core_stall_o && (perf_stall_cnt_r != 32'hFFFF_FFFF)) begin
                perf_stall_cnt_r <= perf_stall_cnt_r + 32'd1;
            end else begin
                perf_stall_cnt_r <= perf_stall_cnt_r;
            end
            if (aux_gnt_s && (perf_aux_cnt_r != 32'hFFFF_FFFF)) begin
                perf_aux_cnt_r <= perf_aux_cnt_r + 32'd1;
            end else begin
                perf_aux_cnt_r <= perf_aux_cnt_r;
            end
        end
    end

    assign perf_stall_cnt_o = perf_stall_cnt_r;
    assign perf_aux_cnt_o   = perf_aux_cnt_r;
`else
    assign perf_stall_cnt_o = 32'h0000_0000;
    assign perf_aux_cnt_o   = 32'h0000_0000;
`endif

endmodule
